key_conditioner: RTL and testbench

Input conditioning stage between the board push-buttons and the timer controller. Synchronises the raw active-low keys, debounces each one independently, and produces clean debounced levels plus single-cycle press and release pulses. Optional per-key auto-repeat lets a held key step a value while the set key is down. Its outputs feed the reset, set and start/stop inputs of the timer controller directly, in place of raw inverted keys.

---
 rtl/key_conditioner_if.sv | 30 +++
 rtl/key_conditioner.sv | 119 +++++++++++
 tb/tb_key_conditioner.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - key conditioner signal bundle
//
// Purpose: groups the raw key inputs and the conditioned key outputs.
// Ports (signals):
//    key_n         raw active-low keys, driven by the board side (master)
//    pressed       debounced active-high level per key
//    press_pulse   one-cycle pulse on accepted press and on each auto-repeat
//    release_pulse one-cycle pulse on accepted release
interface key_conditioner_if #(
   parameter int N_KEYS = 3
);
   logic [N_KEYS-1:0] key_n;
   logic [N_KEYS-1:0] pressed;
   logic [N_KEYS-1:0] press_pulse;
   logic [N_KEYS-1:0] release_pulse;

   modport master (
      output key_n,
      input  pressed,
      input  press_pulse,
      input  release_pulse
   );

   modport slave (
      input  key_n,
      output pressed,
      output press_pulse,
      output release_pulse
   );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronise, debounce and auto-repeat push-buttons
//
// Purpose: per key, a 2-flop synchroniser, a stability-count debouncer and an
// optional auto-repeat state machine; every output is registered.
// Ports:
//    clk    system clock
//    reset  synchronous active-high reset
//    kbus   key_conditioner_if.slave (key_n in; pressed/press_pulse/release_pulse out)
module key_conditioner #(
   parameter int                N_KEYS          = 3,
   parameter int                DEBOUNCE_CYCLES = 1000000,
   parameter int                REPEAT_DELAY    = 25000000,
   parameter int                REPEAT_RATE     = 5000000,
   parameter logic [N_KEYS-1:0] REPEAT_MASK     = {N_KEYS{1'b0}}
) (
   input  logic               clk,
   input  logic               reset,
   key_conditioner_if.slave   kbus
);
   localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_RATE  = 2'd2
   } state_t;

   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;
   logic [N_KEYS-1:0] r_stable;
   logic [N_KEYS-1:0] r_press_pulse;
   logic [N_KEYS-1:0] r_release_pulse;
   logic [CNT_W-1:0]  r_cnt     [N_KEYS];
   logic [REP_W-1:0]  r_rep_cnt [N_KEYS];
   state_t            r_state   [N_KEYS];

   logic [N_KEYS-1:0] w_s;
   logic [N_KEYS-1:0] w_accept;

   assign w_s = ~r_sync2;

   // A level change is accepted on the edge where the input has already
   // differed for DEBOUNCE_CYCLES-1 previous cycles and still differs.
   always_comb begin
      w_accept = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         w_accept[i] = (w_s[i] != r_stable[i]) && (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1         <= '1;
         r_sync2         <= '1;
         r_stable        <= '0;
         r_press_pulse   <= '0;
         r_release_pulse <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            r_cnt[i]     <= '0;
            r_rep_cnt[i] <= '0;
            r_state[i]   <= ST_IDLE;
         end
      end else begin
         r_sync1 <= kbus.key_n;
         r_sync2 <= r_sync1;
         for (int i = 0; i < N_KEYS; i++) begin
            r_press_pulse[i]   <= 1'b0;
            r_release_pulse[i] <= 1'b0;

            // debouncer
            if (w_s[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_stable[i] <= w_s[i];
               r_cnt[i]    <= '0;
               if (w_s[i]) r_press_pulse[i]   <= 1'b1;
               else        r_release_pulse[i] <= 1'b1;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end

            // auto-repeat; rep_cnt holds cycles remaining minus one, so a
            // zero count fires on this edge
            case (r_state[i])
               ST_IDLE: begin
                  if (REPEAT_MASK[i] && w_accept[i] && w_s[i]) begin
                     r_rep_cnt[i] <= REP_W'(REPEAT_DELAY - 1);
                     r_state[i]   <= ST_DELAY;
                  end
               end
               ST_DELAY, ST_RATE: begin
                  // stable is high here, so any accept is a release; it
                  // wins over a due repeat pulse
                  if (w_accept[i]) begin
                     r_rep_cnt[i] <= '0;
                     r_state[i]   <= ST_IDLE;
                  end else if (r_rep_cnt[i] == '0) begin
                     r_press_pulse[i] <= 1'b1;
                     r_rep_cnt[i]     <= REP_W'(REPEAT_RATE - 1);
                     r_state[i]       <= ST_RATE;
                  end else begin
                     r_rep_cnt[i] <= r_rep_cnt[i] - REP_W'(1);
                  end
               end
               default: begin
                  r_rep_cnt[i] <= '0;
                  r_state[i]   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign kbus.pressed       = r_stable;
   assign kbus.press_pulse   = r_press_pulse;
   assign kbus.release_pulse = r_release_pulse;
endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - self-checking bench for key_conditioner
module tb_key_conditioner;
   localparam int N   = 3;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RR  = 3;
   localparam logic [N-1:0] MASK = 3'b010;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   key_conditioner_if #(.N_KEYS(N)) kif ();

   key_conditioner #(
      .N_KEYS(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
   ) dut (
      .clk(clk), .reset(reset), .kbus(kif.slave)
   );

   // reference model: level history and press age
   logic [N-1:0] mask_v;
   logic [N-1:0] m_s1, m_s2, m_stable, m_pp, m_rp;
   int m_run [N];
   int m_age [N];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pp_cnt [N];
   int rp_cnt [N];
   int pp_last [N];
   int rp_last [N];
   int rep_q [$];

   task automatic model(input logic [N-1:0] kn, input logic rst);
      logic s, pp, rp;
      if (rst) begin
         m_s1 = '1; m_s2 = '1; m_stable = '0; m_pp = '0; m_rp = '0;
         for (int i = 0; i < N; i++) begin m_run[i] = 0; m_age[i] = 0; end
      end else begin
         for (int i = 0; i < N; i++) begin
            s = ~m_s2[i]; pp = 1'b0; rp = 1'b0;
            if (s != m_stable[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_stable[i] = s; m_run[i] = 0;
                  if (s) begin pp = 1'b1; m_age[i] = 0; end
                  else rp = 1'b1;
               end
            end else m_run[i] = 0;
            if (m_stable[i] && !pp) m_age[i]++;
            if (mask_v[i] && m_stable[i] && !pp && m_age[i] >= RD && ((m_age[i] - RD) % RR) == 0)
               pp = 1'b1;
            m_pp[i] = pp; m_rp[i] = rp;
         end
         m_s2 = m_s1; m_s1 = kn;
      end
   endtask

   task automatic chk_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic [N-1:0] kn, input logic rst);
      @(negedge clk);
      kif.key_n = kn;
      reset = rst;
      @(posedge clk);
      model(kn, rst);
      #1;
      cyc++;
      chk_vec("pressed", kif.pressed, m_stable);
      chk_vec("press_pulse", kif.press_pulse, m_pp);
      chk_vec("release_pulse", kif.release_pulse, m_rp);
      for (int i = 0; i < N; i++) begin
         if (kif.press_pulse[i]) begin
            pp_cnt[i]++; pp_last[i] = cyc;
            if (i == 1) rep_q.push_back(cyc);
         end
         if (kif.release_pulse[i]) begin rp_cnt[i]++; rp_last[i] = cyc; end
      end
   endtask

   task automatic hold(input logic [N-1:0] kn, input int n);
      for (int k = 0; k < n; k++) step(kn, 1'b0);
   endtask

   initial begin
      int pre, base_pp, base_rp, t, nexp;
      mask_v = MASK;
      kif.key_n = '1;
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         pp_cnt[i] = 0; rp_cnt[i] = 0; pp_last[i] = -1; rp_last[i] = -1;
      end
      model('1, 1'b1);

      // reset state
      step('1, 1'b1); step('1, 1'b1);
      chk_vec("reset_pressed", kif.pressed, 3'b000);
      hold('1, 3);

      // clean press on key 0
      pre = cyc; base_pp = pp_cnt[0];
      hold(3'b110, 20);
      chk_int("clean_rise_cycle", pp_last[0], pre + 1 + DEB + 1);
      chk_int("clean_one_pulse", pp_cnt[0] - base_pp, 1);
      base_rp = rp_cnt[0]; pre = cyc;
      hold('1, 10);
      chk_int("clean_release", rp_cnt[0] - base_rp, 1);
      chk_int("clean_release_cycle", rp_last[0], pre + DEB + 2);

      // bounce on key 2 with random short dwell
      base_pp = pp_cnt[2];
      for (int b = 0; b < 4; b++) hold((b % 2 == 0) ? 3'b011 : 3'b111, $urandom_range(1, DEB - 1));
      pre = cyc;
      hold(3'b011, 12);
      chk_int("bounce_one_pulse", pp_cnt[2] - base_pp, 1);
      chk_int("bounce_rise_cycle", pp_last[2], pre + DEB + 2);
      hold('1, 10);

      // glitch rejection on key 0
      base_pp = pp_cnt[0]; base_rp = rp_cnt[0];
      hold(3'b110, 3);
      hold('1, 10);
      for (int g = 0; g < 4; g++) begin
         hold(3'b110, $urandom_range(1, DEB - 1));
         hold('1, $urandom_range(1, 5));
      end
      hold('1, 6);
      chk_int("glitch_no_press", pp_cnt[0] - base_pp, 0);
      chk_int("glitch_no_release", rp_cnt[0] - base_rp, 0);

      // auto-repeat on key 1, held 30 cycles
      rep_q.delete();
      pre = cyc; base_rp = rp_cnt[1];
      hold(3'b101, 30);
      hold('1, 15);
      t = pre + DEB + 2;
      nexp = 1;
      for (int c = t + RD; c < pre + 31 + DEB + 1; c += RR) nexp++;
      chk_int("repeat_count", rep_q.size(), nexp);
      for (int k = 0; k < rep_q.size() && k < nexp; k++)
         chk_int("repeat_cycle", rep_q[k], (k == 0) ? t : t + RD + (k - 1) * RR);
      chk_int("repeat_release", rp_cnt[1] - base_rp, 1);
      chk_int("repeat_release_cycle", rp_last[1], pre + 31 + DEB + 1);

      // reset while key 0 held
      pre = cyc;
      hold(3'b110, DEB + 3);
      chk_int("prereset_rise", pp_last[0], pre + DEB + 2);
      step(3'b110, 1'b1);
      chk_vec("inreset_pressed", kif.pressed, 3'b000);
      step(3'b110, 1'b1);
      pre = cyc; base_pp = pp_cnt[0];
      hold(3'b110, 12);
      chk_int("postreset_one_pulse", pp_cnt[0] - base_pp, 1);
      chk_int("postreset_rise", pp_last[0], pre + DEB + 2);
      hold('1, 10);

      // simultaneous press on keys 0 and 2
      pre = cyc;
      hold(3'b010, 10);
      chk_int("simul_key0", pp_last[0], pre + DEB + 2);
      chk_int("simul_key2", pp_last[2], pre + DEB + 2);
      hold('1, 10);

      // random key activity with occasional reset
      begin
         logic [N-1:0] kn;
         kn = '1;
         for (int r = 0; r < 600; r++) begin
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 5) == 0) kn[i] = ~kn[i];
            step(kn, ($urandom_range(0, 199) == 0));
         end
      end
      hold('1, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
